mem_port_sched: RTL

Byte-serial memory-bus scheduler that shares the single 8-bit RAM/IO port between the instruction-fetch requester and the load/store requester.
- Serialises 1/2/4-byte requests into per-byte bus cycles and assembles read data little-endian.
- Gives the data side fixed priority, aborts in-flight fetches on a branch flush, and throttles UART writes on `io_buffer_full`.
- Sits between the IF/MEM pipeline stages and the `mem_din/mem_dout/mem_a/mem_wr` pins of the CPU top.

---
 rtl/mem_port_pkg.sv | 39 +++
 rtl/mem_port_sched_if.sv | 37 +++
 rtl/mem_port_sched.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the byte-serial memory port scheduler.
// Op/len codes, I/O select default, state encoding and length decode.
package mem_port_pkg;

  localparam logic [1:0] DEF_IO_SEL = 2'b11;
  localparam int         DEF_LEN_W  = 2;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    LEN_1  = 2'b00,
    LEN_2  = 2'b01,
    LEN_4X = 2'b10,
    LEN_4  = 2'b11
  } len_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_IOWAIT = 3'd3,
    ST_IOGAP  = 3'd4
  } state_e;

  // The unused code 10 decodes as a full word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_1:   len_bytes = 3'd1;
      LEN_2:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_sched_if.sv
// Requester and byte-bus signals of the memory port scheduler.
// slave = scheduler side, master = pipeline/bus side.
interface mem_port_sched_if
  import mem_port_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
);
  logic             flush;
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_done;
  logic [31:0]      if_data;
  logic [1:0]       dm_op;
  logic [LEN_W-1:0] dm_len;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic             dm_done;
  logic [31:0]      dm_rdata;
  logic [7:0]       mem_din;
  logic [7:0]       mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic             io_buffer_full;

  modport slave (
    input  flush, if_req, if_addr, dm_op, dm_len, dm_addr, dm_wdata,
           mem_din, io_buffer_full,
    output if_done, if_data, dm_done, dm_rdata, mem_dout, mem_a, mem_wr
  );

  modport master (
    output flush, if_req, if_addr, dm_op, dm_len, dm_addr, dm_wdata,
           mem_din, io_buffer_full,
    input  if_done, if_data, dm_done, dm_rdata, mem_dout, mem_a, mem_wr
  );

endinterface

// File: rtl/mem_port_sched.sv
// Shares one 8-bit RAM/IO port between instruction fetch and load/store,
// serialising word/half/byte requests into per-byte bus cycles.
//
// Handshake: a requester holds its request (if_req / dm_op != 0) stable until
// its one-cycle *_done pulse (or flush for fetch); the cycle carrying a done
// pulse is IDLE and that requester is masked from being re-accepted in it.
module mem_port_sched
  import mem_port_pkg::*;
#(
  parameter logic [1:0] IO_SEL = DEF_IO_SEL,
  parameter int         LEN_W  = DEF_LEN_W
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  mem_port_sched_if.slave         bus,
  output state_e                  state_dbg
);

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  nbytes_q, nbytes_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        is_fetch_q, is_fetch_d;
  logic        is_io_q, is_io_d;
  logic        if_done_q, if_done_d;
  logic        dm_done_q, dm_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  logic [LEN_W-1:0] len_raw;
  logic [1:0]       lane;
  logic [31:0]      k_ext;
  logic             dm_valid, dm_go, if_go, last_byte;
  logic [7:0]       dout_c;
  logic [31:0]      addr_c;
  logic             wr_c;

  assign len_raw   = bus.dm_len;
  assign lane      = k_q[1:0] - 2'd1;
  assign k_ext     = {29'd0, k_q};
  assign last_byte = (k_q == nbytes_q - 3'd1);
  assign dm_valid  = (bus.dm_op == OP_READ) || (bus.dm_op == OP_WRITE);
  assign dm_go     = dm_valid && !dm_done_q;
  assign if_go     = bus.if_req && !bus.flush && !if_done_q && !dm_go;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    buf_d      = buf_q;
    is_fetch_d = is_fetch_q;
    is_io_d    = is_io_q;
    if_done_d  = 1'b0;
    dm_done_d  = 1'b0;
    if_data_d  = if_data_q;
    dm_rdata_d = dm_rdata_q;
    addr_c     = 32'd0;
    dout_c     = 8'd0;
    wr_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dm_go) begin
          base_d     = bus.dm_addr;
          wdata_d    = bus.dm_wdata;
          nbytes_d   = len_bytes(len_raw[1:0]);
          is_fetch_d = 1'b0;
          is_io_d    = (bus.dm_addr[17:16] == IO_SEL);
          k_d        = 3'd0;
          buf_d      = 32'd0;
          state_d    = (bus.dm_op == OP_READ) ? ST_READ : ST_WRITE;
        end else if (if_go) begin
          base_d     = bus.if_addr;
          nbytes_d   = 3'd4;
          is_fetch_d = 1'b1;
          is_io_d    = 1'b0;
          k_d        = 3'd0;
          buf_d      = 32'd0;
          state_d    = ST_READ;
        end
      end

      ST_READ: begin
        // Once all addresses are out the bus parks at 0 so an I/O read
        // never touches a neighbouring UART address.
        if (k_q < nbytes_q) addr_c = base_q + k_ext;
        if (is_fetch_q && bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          if (k_q != 3'd0) buf_d[{lane, 3'b000} +: 8] = bus.mem_din;
          if (k_q == nbytes_q) begin
            state_d = ST_IDLE;
            if (is_fetch_q) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end else begin
              dm_done_d  = 1'b1;
              dm_rdata_d = buf_d;
            end
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end

      ST_WRITE, ST_IOWAIT: begin
        if (is_io_q && bus.io_buffer_full) begin
          state_d = ST_IOWAIT;
        end else begin
          addr_c = base_q + k_ext;
          dout_c = wdata_q[{k_q[1:0], 3'b000} +: 8];
          wr_c   = 1'b1;
          if (is_io_q) begin
            state_d = ST_IOGAP;
          end else if (last_byte) begin
            state_d   = ST_IDLE;
            dm_done_d = 1'b1;
          end else begin
            state_d = ST_WRITE;
            k_d     = k_q + 3'd1;
          end
        end
      end

      ST_IOGAP: begin
        if (last_byte) begin
          state_d   = ST_IDLE;
          dm_done_d = 1'b1;
        end else begin
          state_d = ST_WRITE;
          k_d     = k_q + 3'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      k_q        <= 3'd0;
      nbytes_q   <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      is_fetch_q <= 1'b0;
      is_io_q    <= 1'b0;
      if_done_q  <= 1'b0;
      dm_done_q  <= 1'b0;
      if_data_q  <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      k_q        <= k_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      is_fetch_q <= is_fetch_d;
      is_io_q    <= is_io_d;
      if_done_q  <= if_done_d;
      dm_done_q  <= dm_done_d;
      if_data_q  <= if_data_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.dm_done  = dm_done_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.mem_a    = addr_c;
  assign bus.mem_dout = dout_c;
  assign bus.mem_wr   = wr_c && rdy_in;
  assign state_dbg    = state_q;

endmodule
